// File: rtl/niu_sio_rx.sv
// niu_sio_rx: SIU->NIU outbound receive stage. Assembles header + optional 4-beat payload
// into a single-entry valid/ready holding register. Parity checking: NIU_SIO_RX_PARITY_CHK_EN.
module niu_sio_rx (
    input  logic         iol2clk,
    input  logic         rst_l,
    input  logic         sio_niu_hdr_vld,
    input  logic         sio_niu_datareq,
    input  logic [127:0] sio_niu_data,
    input  logic [7:0]   sio_niu_parity,
    output logic         rx_pkt_vld,
    input  logic         rx_pkt_rdy,
    output logic [127:0] rx_hdr,
    output logic [511:0] rx_payload,
    output logic         rx_has_data,
    output logic [4:0]   rx_par_err,
    output logic         rx_proto_err,
    output logic         rx_ovfl,
    output logic [15:0]  rx_pkt_cnt
);
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PAYLOAD = 1'b1;

    logic         state;
    logic [1:0]   bcnt;
    logic [127:0] asm_hdr;
    logic [383:0] asm_payload;  // beats 0..2; beat 3 is taken straight from the bus
    logic [3:0]   asm_par;      // bit0 header, bits1..3 beats 0..2
    logic         slice_err;

    logic         cmp_done;
    logic [127:0] cmp_hdr;
    logic [511:0] cmp_payload;
    logic         cmp_has_data;
    logic [4:0]   cmp_par;
    logic         xfer;
    logic         load;

`ifdef NIU_SIO_RX_PARITY_CHK_EN
    logic [7:0] slice_bad;
    always_comb begin
        slice_bad = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            slice_bad[i] = (^sio_niu_data[16*i +: 16]) != sio_niu_parity[i];
        end
    end
    assign slice_err = |slice_bad;
`else
    logic unused_parity;
    assign unused_parity = ^sio_niu_parity;
    assign slice_err     = 1'b0;
`endif

    // A header always restarts assembly, so a no-payload header completes even mid-payload.
    always_comb begin
        cmp_done     = 1'b0;
        cmp_hdr      = asm_hdr;
        cmp_payload  = '0;
        cmp_has_data = 1'b0;
        cmp_par      = '0;
        if (sio_niu_hdr_vld) begin
            if (!sio_niu_datareq) begin
                cmp_done = 1'b1;
                cmp_hdr  = sio_niu_data;
                cmp_par  = {4'b0000, slice_err};
            end
        end else if (state == ST_PAYLOAD && bcnt == 2'd3) begin
            cmp_done     = 1'b1;
            cmp_payload  = {sio_niu_data, asm_payload};
            cmp_has_data = 1'b1;
            cmp_par      = {slice_err, asm_par};
        end
    end

    assign xfer = rx_pkt_vld & rx_pkt_rdy;
    assign load = cmp_done & (~rx_pkt_vld | rx_pkt_rdy);

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= ST_IDLE;
            bcnt         <= '0;
            asm_hdr      <= '0;
            asm_payload  <= '0;
            asm_par      <= '0;
            rx_pkt_vld   <= 1'b0;
            rx_hdr       <= '0;
            rx_payload   <= '0;
            rx_has_data  <= 1'b0;
            rx_par_err   <= '0;
            rx_proto_err <= 1'b0;
            rx_ovfl      <= 1'b0;
            rx_pkt_cnt   <= '0;
        end else begin
            if (sio_niu_hdr_vld) begin
                rx_proto_err <= (state == ST_PAYLOAD);
                asm_hdr      <= sio_niu_data;
                asm_payload  <= '0;
                asm_par      <= {3'b000, slice_err};
                bcnt         <= '0;
                state        <= sio_niu_datareq ? ST_PAYLOAD : ST_IDLE;
            end else begin
                rx_proto_err <= 1'b0;
                if (state == ST_PAYLOAD) begin
                    case (bcnt)
                        2'd0: begin asm_payload[127:0]   <= sio_niu_data; asm_par[1] <= slice_err; end
                        2'd1: begin asm_payload[255:128] <= sio_niu_data; asm_par[2] <= slice_err; end
                        2'd2: begin asm_payload[383:256] <= sio_niu_data; asm_par[3] <= slice_err; end
                        default: state <= ST_IDLE;
                    endcase
                    bcnt <= bcnt + 2'd1;
                end
            end

            rx_ovfl <= cmp_done & rx_pkt_vld & ~rx_pkt_rdy;

            if (load) begin
                rx_pkt_vld  <= 1'b1;
                rx_hdr      <= cmp_hdr;
                rx_payload  <= cmp_payload;
                rx_has_data <= cmp_has_data;
                rx_par_err  <= cmp_par;
            end else if (xfer) begin
                rx_pkt_vld <= 1'b0;
            end

            if (xfer) begin
                rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_niu_sio_rx.sv
// tb_niu_sio_rx: randomized + directed bench for niu_sio_rx against a packet-level model.
// Parity expectations follow NIU_SIO_RX_PARITY_CHK_EN as seen by this compile.
module tb_niu_sio_rx;
    logic         iol2clk = 1'b0;
    logic         rst_l   = 1'b0;
    logic         hv      = 1'b0;
    logic         dr      = 1'b0;
    logic [127:0] data    = '0;
    logic [7:0]   par     = '0;
    logic         rdy     = 1'b0;

    logic         rx_pkt_vld;
    logic [127:0] rx_hdr;
    logic [511:0] rx_payload;
    logic         rx_has_data;
    logic [4:0]   rx_par_err;
    logic         rx_proto_err;
    logic         rx_ovfl;
    logic [15:0]  rx_pkt_cnt;

    niu_sio_rx dut (
        .iol2clk         (iol2clk),
        .rst_l           (rst_l),
        .sio_niu_hdr_vld (hv),
        .sio_niu_datareq (dr),
        .sio_niu_data    (data),
        .sio_niu_parity  (par),
        .rx_pkt_vld      (rx_pkt_vld),
        .rx_pkt_rdy      (rdy),
        .rx_hdr          (rx_hdr),
        .rx_payload      (rx_payload),
        .rx_has_data     (rx_has_data),
        .rx_par_err      (rx_par_err),
        .rx_proto_err    (rx_proto_err),
        .rx_ovfl         (rx_ovfl),
        .rx_pkt_cnt      (rx_pkt_cnt)
    );

    always #5 iol2clk = ~iol2clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: holding register contents plus the packet being collected.
    logic         m_vld;
    logic [127:0] m_hdr;
    logic [511:0] m_payload;
    logic         m_has;
    logic [4:0]   m_perr;
    logic         m_proto;
    logic         m_ovfl;
    logic [15:0]  m_cnt;
    bit           inflight;
    logic [127:0] p_hdr;
    logic [127:0] p_beats[$];
    logic [4:0]   p_perr;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] good_par(input logic [127:0] x);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^x[16*i +: 16];
        return p;
    endfunction

    function automatic logic perr_of(input logic [127:0] x, input logic [7:0] p);
`ifdef NIU_SIO_RX_PARITY_CHK_EN
        return |(good_par(x) ^ p);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_vld = 0; m_hdr = '0; m_payload = '0; m_has = 0; m_perr = '0;
        m_proto = 0; m_ovfl = 0; m_cnt = '0;
        inflight = 0; p_hdr = '0; p_beats.delete(); p_perr = '0;
    endtask

    task automatic model_step();
        bit done;
        bit xfer;
        logic [511:0] pl;
        done = 0;
        xfer = m_vld && rdy;
        m_proto = 0;
        m_ovfl  = 0;
        if (hv) begin
            m_proto  = inflight;
            p_hdr    = data;
            p_beats.delete();
            p_perr   = {4'b0, perr_of(data, par)};
            inflight = dr;
            done     = !dr;
        end else if (inflight) begin
            p_perr[p_beats.size() + 1] = perr_of(data, par);
            p_beats.push_back(data);
            if (p_beats.size() == 4) begin
                inflight = 0;
                done     = 1;
            end
        end
        if (xfer) m_cnt = m_cnt + 16'd1;
        if (done && m_vld && !rdy) begin
            m_ovfl = 1;
        end else if (done) begin
            pl = '0;
            foreach (p_beats[k]) pl[128*k +: 128] = p_beats[k];
            m_vld = 1; m_hdr = p_hdr; m_payload = pl;
            m_has = (p_beats.size() == 4); m_perr = p_perr;
        end else if (xfer) begin
            m_vld = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        check_val({ctx, ".vld"},     rx_pkt_vld,   m_vld);
        check_val({ctx, ".hdr"},     rx_hdr,       m_hdr);
        check_val({ctx, ".payload"}, rx_payload,   m_payload);
        check_val({ctx, ".has"},     rx_has_data,  m_has);
        check_val({ctx, ".perr"},    rx_par_err,   m_perr);
        check_val({ctx, ".proto"},   rx_proto_err, m_proto);
        check_val({ctx, ".ovfl"},    rx_ovfl,      m_ovfl);
        check_val({ctx, ".cnt"},     rx_pkt_cnt,   m_cnt);
    endtask

    task automatic drive_cycle(input string ctx, input logic h, input logic d,
                               input logic [127:0] x, input logic [7:0] flip, input logic r);
        hv = h; dr = d; data = x; par = good_par(x) ^ flip; rdy = r;
        @(posedge iol2clk);
        #1;
        model_step();
        check_all(ctx);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rnd_flip();
        logic [7:0] f;
        f = '0;
        if ($urandom_range(0, 5) == 0) f[$urandom_range(0, 7)] = 1'b1;
        return f;
    endfunction

    function automatic logic rnd_rdy();
        return $urandom_range(0, 9) < 7;
    endfunction

    localparam logic [127:0] HDR_A5 = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_00A5;

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge iol2clk);
        #1;
        check_all("reset");
        @(negedge iol2clk);
        rst_l = 1'b1;

        // No-payload packet, then idle with rdy to see the count step
        drive_cycle("np_hdr", 1, 0, HDR_A5, 8'h00, 1);
        drive_cycle("np_idle", 0, 0, '0, 8'h00, 1);
        drive_cycle("np_idle2", 0, 1, rnd128(), 8'h00, 0);

        // Payload packet
        drive_cycle("pl_hdr", 1, 1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 8'h00, 0);
        drive_cycle("pl_b0", 0, 0, {8{16'h1111}}, 8'h00, 0);
        drive_cycle("pl_b1", 0, 0, {8{16'h2222}}, 8'h00, 0);
        drive_cycle("pl_b2", 0, 0, {8{16'h3333}}, 8'h00, 0);
        drive_cycle("pl_b3", 0, 0, {8{16'h4444}}, 8'h00, 0);
        drive_cycle("pl_idle", 0, 0, '0, 8'h00, 1);

        // Backpressure: A held, B dropped, C completes with rdy
        drive_cycle("bp_a", 1, 0, rnd128(), 8'h00, 0);
        drive_cycle("bp_b", 1, 0, rnd128(), 8'h00, 0);
        drive_cycle("bp_hold", 0, 0, '0, 8'h00, 0);
        drive_cycle("bp_c_hdr", 1, 1, rnd128(), 8'h00, 0);
        for (int b = 0; b < 3; b++) drive_cycle("bp_c_beat", 0, 0, rnd128(), 8'h00, 0);
        drive_cycle("bp_c_last", 0, 0, rnd128(), 8'h00, 1);
        drive_cycle("bp_drain", 0, 0, '0, 8'h00, 1);

        // Protocol abort on beat 2
        drive_cycle("pe_hdr", 1, 1, rnd128(), 8'h00, 1);
        drive_cycle("pe_b0", 0, 0, rnd128(), 8'h00, 1);
        drive_cycle("pe_b1", 0, 0, rnd128(), 8'h00, 1);
        drive_cycle("pe_new", 1, 0, rnd128(), 8'h00, 1);
        drive_cycle("pe_idle", 0, 0, '0, 8'h00, 1);
        drive_cycle("pe_idle2", 0, 0, '0, 8'h00, 1);

        // Parity: beat 2 slice 3 flipped
        drive_cycle("par_hdr", 1, 1, rnd128(), 8'h00, 1);
        drive_cycle("par_b0", 0, 0, rnd128(), 8'h00, 1);
        drive_cycle("par_b1", 0, 0, rnd128(), 8'h00, 1);
        drive_cycle("par_b2", 0, 0, rnd128(), 8'h08, 1);
        drive_cycle("par_b3", 0, 0, rnd128(), 8'h00, 0);
        drive_cycle("par_idle", 0, 0, '0, 8'h00, 1);

        // Reset mid-payload, then a fresh packet
        drive_cycle("rs_hdr", 1, 1, rnd128(), 8'h00, 0);
        drive_cycle("rs_b0", 0, 0, rnd128(), 8'h00, 0);
        drive_cycle("rs_b1", 0, 0, rnd128(), 8'h00, 0);
        #2;
        rst_l = 1'b0;
        hv = 0; dr = 0;
        #1;
        model_reset();
        check_all("rs_async");
        @(posedge iol2clk);
        @(negedge iol2clk);
        rst_l = 1'b1;
        drive_cycle("rs_np", 1, 0, rnd128(), 8'h00, 1);
        drive_cycle("rs_idle", 0, 0, '0, 8'h00, 1);

        // Randomized traffic with occasional aborts, parity errors and backpressure
        begin
            bit abort;
            abort = 0;
            for (int n = 0; n < 300; n++) begin
                int unsigned gap;
                int unsigned nb;
                logic d;
                gap = abort ? 0 : $urandom_range(0, 2);
                for (int unsigned g = 0; g < gap; g++)
                    drive_cycle("rnd_idle", 0, 1'($urandom_range(0, 1)), rnd128(), 8'h00, rnd_rdy());
                d = 1'($urandom_range(0, 1));
                drive_cycle("rnd_hdr", 1, d, rnd128(), rnd_flip(), rnd_rdy());
                abort = 0;
                if (d) begin
                    nb = 4;
                    if ($urandom_range(0, 9) == 0) begin
                        nb = $urandom_range(0, 3);
                        abort = 1;
                    end
                    for (int unsigned b = 0; b < nb; b++)
                        drive_cycle("rnd_beat", 0, 1'($urandom_range(0, 1)), rnd128(), rnd_flip(), rnd_rdy());
                end
            end
            for (int i = 0; i < 3; i++) drive_cycle("rnd_drain", 0, 0, '0, 8'h00, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/niu_sio_rx.md
# niu_sio_rx

Receive stage on the NIU side of the SIU-to-NIU outbound path. Captures each SIU packet (one header cycle plus an optional four-cycle 64-byte payload) from the `sio_niu_*` bus. Checks per-slice parity and assembles the packet into a single-entry holding register. Presents the packet to the NIU core through a valid/ready handshake.

## Interface
Parameters:
- none

Ports:
- `iol2clk`  in  1  sole clock, all state on rising edge
- `rst_l`  in  1  reset, asynchronous assert, active-low
- `sio_niu_hdr_vld`  in  1  header cycle; `sio_niu_data` carries the 128-bit header
- `sio_niu_datareq`  in  1  sampled with `hdr_vld`: 1 = four payload beats follow, 0 = write-ack/no payload
- `sio_niu_data`  in  128  header or payload beat
- `sio_niu_parity`  in  8  bit i covers `data[16i+15:16i]`
- `rx_pkt_vld`  out  1  holding register full
- `rx_pkt_rdy`  in  1  consumer accepts when `vld & rdy`
- `rx_hdr`  out  128  captured header
- `rx_payload`  out  512  beat k in `[128k+127:128k]`, k=0 first; zero when no payload
- `rx_has_data`  out  1  packet carried payload
- `rx_par_err`  out  5  bit0 header, bits1..4 beats 0..3
- `rx_proto_err`  out  1  one-cycle pulse, packet aborted
- `rx_ovfl`  out  1  one-cycle pulse, completed packet dropped (holding register busy)
- `rx_pkt_cnt`  out  16  accepted-packet counter

## Operation
- FSM states: IDLE, PAYLOAD; 2-bit beat counter `bcnt`.
- IDLE, `hdr_vld=1`, `datareq=0`:
  - latch header and parity result;
  - packet complete this cycle; stay in IDLE.
- IDLE, `hdr_vld=1`, `datareq=1`:
  - latch header into assembly buffer;
  - `bcnt<=0`; go to PAYLOAD.
- PAYLOAD: each cycle unconditionally captures beat `bcnt` and increments `bcnt`. The bus has no gaps.
- PAYLOAD, `bcnt=3`: fourth beat captured; packet complete; return to IDLE.
- PAYLOAD, `hdr_vld=1`: protocol violation.
  - pulse `rx_proto_err`; discard partial packet;
  - process the new header exactly as from IDLE. It may re-enter PAYLOAD.
- `hdr_vld`/`datareq` in IDLE without `hdr_vld`: ignored.
- On completion:
  - if holding register empty, or `rx_pkt_rdy=1` this cycle: load assembly buffer into outputs; `rx_pkt_vld<=1`.
  - otherwise: drop the new packet; pulse `rx_ovfl`; holding contents unchanged.
- Handshake:
  - `vld & rdy` with no simultaneous completion: `rx_pkt_vld<=0`.
  - `vld & rdy` with simultaneous completion: old transfers, new loads, `vld` stays 1.
  - `rx_hdr`, `rx_payload`, `rx_has_data` and `rx_par_err` are stable while `vld & !rdy`.
- `rx_pkt_cnt` increments on each `vld & rdy`; wraps 0xFFFF->0.

## Timing
- Reset (async, `rst_l=0`): IDLE, `bcnt=0`, assembly buffer cleared; all outputs 0. A packet in flight is discarded; the first valid header after deassertion starts fresh.
- No-payload packet: header at cycle T -> `rx_pkt_vld=1` at T+1.
- Payload packet: header T, beats T+1..T+4 -> `rx_pkt_vld=1` at T+5.
- Back-to-back:
  - header at T+5 after a payload packet whose header was at T is legal;
  - header on consecutive cycles (no-payload) is legal.
- `rx_proto_err` and `rx_ovfl` are registered and asserted for exactly one cycle, at the cycle after the triggering edge.
- `rx_pkt_vld` is registered; `rx_pkt_rdy` has no combinational path to any output.

## Configuration
- `NIU_SIO_RX_PARITY_CHK_EN` defined:
  - each header/beat slice i flags an error when `^data[16i+15:16i] != parity[i]`;
  - the OR of the 8 slice results goes to the matching `rx_par_err` bit.
  - Packets with parity errors are still delivered.
- Undefined: `rx_par_err` tied to 0; no parity logic; `sio_niu_parity` unused.

## Test plan
- No-payload packet: `hdr_vld=1, datareq=0, data=0x…A5`, `rdy=1` at T -> `vld=1` at T+1 with `rx_hdr=0x…A5`, `rx_has_data=0`, `rx_payload=0`; `rx_pkt_cnt=1`.
- Payload packet: header at T, beats 0x11…,0x22…,0x33…,0x44… -> at T+5 `rx_payload[127:0]=0x11…`, `[511:384]=0x44…`, `rx_has_data=1`.
- Backpressure: `rdy=0`, two packets complete -> first held stable, second dropped with one `rx_ovfl` pulse. Raise `rdy` on a cycle coinciding with a third completion -> first transfers, third loads, `vld` stays 1.
- Protocol abort: header with `datareq=1`, then `hdr_vld=1, datareq=0` on beat 2 -> one `rx_proto_err` pulse; only the second packet delivered.
- Parity (macro defined): beat 2 slice 3 parity flipped -> `rx_par_err=5'b01000`. Macro undefined -> `rx_par_err=0`.
- Reset mid-payload: `rst_l=0` after beat 1 -> outputs 0 immediately. After release, a new no-payload packet is delivered at T+1 with `rx_pkt_cnt=1`.
